// File: rtl/load_store_unit.sv
// load_store_unit: bridges the datapath data-memory port to a valid/ready bus.
// Each load/store becomes one bus transaction; stall holds the pipeline until
// the access commits, and misaligned accesses or bus timeouts pulse fault.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   MemRead, MemWrite       load / store request (both high = store)
//   funct3                  access size and sign
//   Addr, WrData            effective address, store data
//   RdData                  extended load result, non-zero only in DONE
//   stall, fault            pipeline hold, one-cycle error pulse
//   bus_req/we/addr/wdata/wstrb, bus_ready, bus_rdata   data bus
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [3:0]       strb_q, strb_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             tmo_q, tmo_d;

  logic             access;
  logic             misalign;
  logic [1:0]       size_c;
  logic [3:0]       strb_c;
  logic [31:0]      wdata_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;

  assign access = MemRead | MemWrite;

  // Request decode: size, alignment, store lanes
  always_comb begin
    size_c  = SZ_W;
    strb_c  = 4'b0000;
    wdata_c = 32'd0;
    case (funct3[1:0])
      2'b00:   size_c = SZ_B;
      2'b01:   size_c = SZ_H;
      default: size_c = SZ_W;
    endcase
    misalign = access & (((size_c == SZ_H) & Addr[0]) |
                         ((size_c == SZ_W) & (Addr[1:0] != 2'b00)));
    if (MemWrite) begin
      case (size_c)
        SZ_B: begin
          strb_c  = 4'b0001 << Addr[1:0];
          wdata_c = {4{WrData[7:0]}};
        end
        SZ_H: begin
          strb_c  = 4'b0011 << Addr[1:0];
          wdata_c = {2{WrData[15:0]}};
        end
        default: begin
          strb_c  = 4'b1111;
          wdata_c = WrData;
        end
      endcase
    end
  end

  // State and captured transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      strb_q  <= 4'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      off_q   <= 2'd0;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state, stall and fault
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sign_d  = sign_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    stall   = 1'b0;
    fault   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !misalign) begin
          stall   = 1'b1;
          state_d = S_REQ;
          addr_d  = {Addr[31:2], 2'b00};
          we_d    = MemWrite;
          strb_d  = strb_c;
          wdata_d = wdata_c;
          size_d  = size_c;
          sign_d  = ~funct3[2];
          off_d   = Addr[1:0];
          cnt_d   = '0;
          rdata_d = 32'd0;
          tmo_d   = 1'b0;
        end else if (misalign) begin
          fault = 1'b1;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus_ready) begin
          if (!we_q) rdata_d = bus_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Request inputs are still high here; returning to IDLE unconditionally
        // keeps the same instruction from launching a second transaction.
        fault   = tmo_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      stall = 1'b0;
      fault = 1'b0;
    end
  end

  // Load extraction from the captured word
  always_comb begin
    case (off_q)
      2'd0:    byte_c = rdata_q[7:0];
      2'd1:    byte_c = rdata_q[15:8];
      2'd2:    byte_c = rdata_q[23:16];
      default: byte_c = rdata_q[31:24];
    endcase
    half_c = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    RdData = 32'd0;
    if (state_q == S_DONE && !tmo_q && !we_q) begin
      case (size_q)
        SZ_B:    RdData = {{24{sign_q & byte_c[7]}}, byte_c};
        SZ_H:    RdData = {{16{sign_q & half_c[15]}}, half_c};
        default: RdData = rdata_q;
      endcase
    end
  end

  assign bus_req   = (state_q == S_REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = strb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Addr, WrData, RdData;
  logic        stall, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .Addr(Addr), .WrData(WrData), .RdData(RdData),
    .stall(stall), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one access; the bus slave asserts ready in REQ cycle number waits+1.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdat,
                        input int waits, input logic [31:0] exp_addr,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rd, input logic exp_fault,
                        input int exp_req, input int exp_stall);
    int n_req, n_stall;
    bit done;
    MemRead = rd; MemWrite = wr; funct3 = f3; Addr = addr; WrData = wd;
    bus_rdata = rdat; bus_ready = 1'b0;
    n_req = 0; n_stall = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (bus_req) begin
        n_req++;
        chk({tag, "_addr"},  bus_addr,  exp_addr);
        chk({tag, "_we"},    32'(bus_we), 32'(wr));
        chk({tag, "_strb"},  32'(bus_wstrb), 32'(exp_strb));
        chk({tag, "_wdata"}, bus_wdata, exp_wdata);
        chk({tag, "_rd_req"}, RdData, 32'd0);
        bus_ready = (n_req == waits + 1);
      end else begin
        bus_ready = 1'b0;
        if (n_stall > 0 && !stall) begin
          done = 1'b1;
          chk({tag, "_rddata"}, RdData, exp_rd);
          chk({tag, "_fault"}, 32'(fault), 32'(exp_fault));
          chk({tag, "_nreq"},  32'(n_req), 32'(exp_req));
          chk({tag, "_nstall"}, 32'(n_stall), 32'(exp_stall));
        end else begin
          chk({tag, "_fault_idle"}, 32'(fault), 32'd0);
        end
      end
      step();
    end
    if (!done) chk({tag, "_done_seen"}, 32'd0, 32'd1);
    MemRead = 1'b0; MemWrite = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_after_req"}, 32'(bus_req), 32'd0);
    step();
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
    Addr = 32'd0; WrData = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
    step(); step();
    @(negedge clk);
    chk("rst_req",   32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall),   32'd0);
    chk("rst_fault", 32'(fault),   32'd0);
    chk("rst_addr",  bus_addr,     32'd0);
    chk("rst_rd",    RdData,       32'd0);
    step();
    reset = 1'b0;
    step();

    // LW, ready in first REQ cycle
    access("lw", 1, 0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0,
           32'h100, 4'b0000, 32'd0, 32'hDEADBEEF, 0, 1, 2);
    // LB / LBU top byte
    access("lb", 1, 0, 3'b000, 32'h203, 32'd0, 32'h80FF1234, 0,
           32'h200, 4'b0000, 32'd0, 32'hFFFFFF80, 0, 1, 2);
    access("lbu", 1, 0, 3'b100, 32'h203, 32'd0, 32'h80FF1234, 0,
           32'h200, 4'b0000, 32'd0, 32'h00000080, 0, 1, 2);
    // LH upper half / LHU lower half
    access("lh", 1, 0, 3'b001, 32'h202, 32'd0, 32'h80FF1234, 1,
           32'h200, 4'b0000, 32'd0, 32'hFFFF80FF, 0, 2, 3);
    access("lhu", 1, 0, 3'b101, 32'h200, 32'd0, 32'h80FF1234, 0,
           32'h200, 4'b0000, 32'd0, 32'h00001234, 0, 1, 2);
    // SH with three wait cycles
    access("sh", 0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'd0, 3,
           32'h300, 4'b1100, 32'hABCDABCD, 32'd0, 0, 4, 5);
    // SB lane 1
    access("sb", 0, 1, 3'b000, 32'h201, 32'h000000A5, 32'd0, 0,
           32'h200, 4'b0010, 32'hA5A5A5A5, 32'd0, 0, 1, 2);
    // Both request lines high: treated as SW, no load data returned
    access("both", 1, 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h12345678, 0,
           32'h400, 4'b1111, 32'hCAFEF00D, 32'd0, 0, 1, 2);
    // Timeout: ready never asserted
    access("tmo", 1, 0, 3'b010, 32'h104, 32'd0, 32'h55555555, 1000,
           32'h104, 4'b0000, 32'd0, 32'd0, 1, 16, 17);

    // Misaligned LW
    MemRead = 1'b1; funct3 = 3'b010; Addr = 32'h101;
    @(negedge clk);
    chk("mis_fault", 32'(fault),   32'd1);
    chk("mis_stall", 32'(stall),   32'd0);
    chk("mis_req",   32'(bus_req), 32'd0);
    chk("mis_rd",    RdData,       32'd0);
    step();
    MemRead = 1'b0;
    @(negedge clk);
    chk("mis_fault_end", 32'(fault),   32'd0);
    chk("mis_req_end",   32'(bus_req), 32'd0);
    step();

    // Reset in the second REQ cycle of a SW
    MemWrite = 1'b1; funct3 = 3'b010; Addr = 32'h500; WrData = 32'h11223344;
    bus_ready = 1'b0;
    step();
    @(negedge clk);
    chk("rr_req1", 32'(bus_req), 32'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rr_stall_in_rst", 32'(stall), 32'd0);
    step();
    @(negedge clk);
    chk("rr_req",   32'(bus_req),   32'd0);
    chk("rr_we",    32'(bus_we),    32'd0);
    chk("rr_addr",  bus_addr,       32'd0);
    chk("rr_wdata", bus_wdata,      32'd0);
    chk("rr_strb",  32'(bus_wstrb), 32'd0);
    chk("rr_stall", 32'(stall),     32'd0);
    MemWrite = 1'b0;
    step();
    reset = 1'b0;
    step();
    access("lw2", 1, 0, 3'b010, 32'h600, 32'd0, 32'h0BADF00D, 0,
           32'h600, 4'b0000, 32'd0, 32'h0BADF00D, 0, 1, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU datapath's data-memory port (address, write data, read data) and a handshaked data bus.
- Turns each load/store into one bus transaction with valid/ready handshake, byte strobes and a timeout.
- Asserts a stall so the PC and register file hold until the access completes.
- Returns the load result, extended according to funct3, to the datapath's result mux.

Parameters:
- TIMEOUT, 16: max cycles in REQ waiting for bus_ready before aborting with fault (must be >=2).
- CNT_W, 5: width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  current instruction is a load.
- MemWrite  input  1  current instruction is a store.
- funct3  input  3  Instr[14:12]; access size/sign.
- Addr  input  32  effective address (ALU result).
- WrData  input  32  store data (rs2).
- RdData  output  32  extended load result; valid in DONE.
- stall  output  1  hold PC and suppress RegWrite this cycle.
- fault  output  1  one-cycle pulse: misaligned access or bus timeout.
- bus_req  output  1  transaction valid.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word-aligned address {Addr[31:2],2'b00}.
- bus_wdata  output  32  lane-replicated store data.
- bus_wstrb  output  4  byte enables; 0000 on reads.
- bus_ready  input  1  slave accepts/completes the transaction this cycle.
- bus_rdata  input  32  read word; valid when bus_ready=1 on a read.

Behaviour:
- Access: access = MemRead|MemWrite. If both are high, the access is a write; RdData=0.
- Size decode: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned. 011/110/111 are treated as word.
- Misaligned (combinational): half with Addr[0]=1, or word with Addr[1:0]!=00.
  - No bus transaction; stall=0.
  - fault=1 that same cycle; RdData=0.
  - The store is dropped.
- FSM states:
  - IDLE: if access and not misaligned, then stall=1 and go to REQ. On that edge, register bus_addr, bus_we, bus_wstrb, bus_wdata, size/sign and Addr[1:0]; clear the counter.
  - REQ: bus_req=1, stall=1, outputs held stable.
    - On bus_ready=1: capture bus_rdata (reads), go to DONE.
    - Otherwise count. When count==TIMEOUT-1 and still no ready: go to DONE with timeout flag set.
  - DONE: bus_req=0, stall=0, RdData driven.
    - On timeout: fault=1 and RdData=0.
    - Unconditionally go to IDLE next edge. The request inputs are still high here and must not retrigger.
- Latency: ready in the first REQ cycle gives stall high for 2 cycles, with commit in the 3rd (DONE).
- Store strobes and data:
  - SB: wstrb=0001<<Addr[1:0], wdata={4{WrData[7:0]}}.
  - SH: wstrb=0011<<Addr[1:0], wdata={2{WrData[15:0]}}.
  - SW: wstrb=1111, wdata=WrData.
- Load extract:
  - Byte lane = Addr[1:0]*8, half lane = Addr[1]*16.
  - Sign- or zero-extend to 32 bits per funct3.
- RdData reads 0 whenever not in DONE.
- Reset: state=IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, captured data and counter all 0.
  - stall=0 and fault=0 while reset is high.
  - Reset during REQ drops bus_req at that edge; the transaction is abandoned.
- bus_ready is ignored outside REQ.

Test Plan:
- LW at Addr=0x100, bus_ready=1 in first REQ cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100, wstrb=0000, stall high 2 cycles, DONE RdData=0xDEADBEEF, fault=0.
- LB Addr=0x203 and LBU Addr=0x203, bus_rdata=0x80FF1234 -> RdData=0xFFFFFF80 and 0x00000080 respectively; bus_addr=0x200.
- SH Addr=0x302, WrData=0x0000ABCD, ready after 3 wait cycles -> bus_we=1, wstrb=1100, wdata=0xABCDABCD, bus outputs stable 4 REQ cycles, stall high 5 cycles.
- LW Addr=0x101 -> no bus_req, stall=0, fault pulse 1 cycle, RdData=0.
- LW with bus_ready never asserted, TIMEOUT=16 -> exactly 16 REQ cycles, then DONE with fault=1, RdData=0, back to IDLE.
- Assert reset in 2nd REQ cycle of a SW -> bus_req=0 and all bus outputs 0 after that edge, stall=0. The following LW after reset completes normally.
